single_cpu: RTL and testbench

- Compact 16-bit single-cycle CPU: 8×16 register file, 256-word instruction memory loaded over UART, 256-word data memory, 16-bit output register.
- Output register drives four LEDs and, together with the PC, a 6-digit multiplexed seven-segment display.
- Top-level board block: clock, reset button, load switch, UART RX pin in; LEDs and display out.

---
 rtl/single_cpu_pkg.sv | 50 +++++
 rtl/single_cpu_uart_rx.sv | 89 ++++++++
 rtl/single_cpu.sv | 170 +++++++++++++++++
 tb/tb_single_cpu.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/single_cpu_pkg.sv
// Shared widths, opcodes and the seven-segment font for the single-cycle CPU.
package single_cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int REG_AW = 3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hE;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/single_cpu_uart_rx.sv
// 8N1 UART receiver with a 2-FF synchroniser and mid-bit sampling.
module uart_rx_8n1 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      valid   <= 1'b0;
      case (state)
        // Only a true high-to-low transition starts a frame, so a low stop bit cannot retrigger.
        S_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CW'(HALF_BIT - 1)) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (rx_sync) begin
              data  <= shift;
              valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/single_cpu.sv
// Board-level single-cycle 16-bit CPU with UART program loader and hex display scan.
module single_cpu
  import single_cpu_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       wait_transport,
  input  logic       uart_rx_pin,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic       led4,
  output logic [6:0] seg,
  output logic [5:0] sel
);

  localparam int SCAN_W = $clog2(SCAN_DIV + 1);

  logic [DATA_W-1:0] imem [0:255];
  logic [DATA_W-1:0] dmem [0:255];
  logic [DATA_W-1:0] regs [0:7];
  logic [DATA_W-1:0] out_reg;
  logic [ADDR_W-1:0] pc, next_pc, load_ptr;
  logic              halted;

  logic [DATA_W-1:0] instr, rd_val, rs1_val, rs2_val, imm6, imm9, wb_val;
  logic [3:0]        op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [7:0]        mem_addr;
  logic              wb_en, dmem_we, out_we, halt_set, exec_en;

  logic [7:0]        rx_data, lo_byte;
  logic              rx_valid, byte_toggle, imem_we;

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit;
  logic [3:0]        nibble;

  uart_rx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk   (CLK),
    .reset (RESET),
    .rx    (uart_rx_pin),
    .data  (rx_data),
    .valid (rx_valid)
  );

  assign instr    = imem[pc];
  assign op       = instr[15:12];
  assign rd       = instr[11:9];
  assign rs1      = instr[8:6];
  assign rs2      = instr[5:3];
  assign imm6     = {{(DATA_W-6){instr[5]}}, instr[5:0]};
  assign imm9     = {{(DATA_W-9){instr[8]}}, instr[8:0]};
  assign rd_val   = (rd  == '0) ? '0 : regs[rd];
  assign rs1_val  = (rs1 == '0) ? '0 : regs[rs1];
  assign rs2_val  = (rs2 == '0) ? '0 : regs[rs2];
  assign mem_addr = rs1_val[7:0] + imm6[7:0];
  assign exec_en  = !RESET && !wait_transport && !halted;

  always_comb begin
    wb_en    = 1'b0;
    wb_val   = '0;
    dmem_we  = 1'b0;
    out_we   = 1'b0;
    halt_set = 1'b0;
    next_pc  = pc + 1'b1;
    case (op)
      OP_NOP:  ;
      OP_ADD:  begin wb_en = 1'b1; wb_val = rs1_val + rs2_val; end
      OP_SUB:  begin wb_en = 1'b1; wb_val = rs1_val - rs2_val; end
      OP_AND:  begin wb_en = 1'b1; wb_val = rs1_val & rs2_val; end
      OP_OR:   begin wb_en = 1'b1; wb_val = rs1_val | rs2_val; end
      OP_XOR:  begin wb_en = 1'b1; wb_val = rs1_val ^ rs2_val; end
      OP_SLT:  begin
        wb_en  = 1'b1;
        wb_val = {{(DATA_W-1){1'b0}}, ($signed(rs1_val) < $signed(rs2_val))};
      end
      OP_ADDI: begin wb_en = 1'b1; wb_val = rs1_val + imm6; end
      OP_LI:   begin wb_en = 1'b1; wb_val = imm9; end
      OP_LW:   begin wb_en = 1'b1; wb_val = dmem[mem_addr]; end
      OP_SW:   dmem_we = 1'b1;
      OP_BEQ:  if (rd_val == rs1_val) next_pc = pc + 8'd1 + imm6[7:0];
      OP_JMP:  next_pc = instr[7:0];
      OP_OUT:  out_we = 1'b1;
      OP_HALT: begin halt_set = 1'b1; next_pc = pc; end
      default: ;
    endcase
  end

  // Load mode parks the PC at 0 and clears halt so the next run starts fresh.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc      <= '0;
      halted  <= 1'b0;
      out_reg <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wait_transport) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      pc     <= next_pc;
      halted <= halt_set;
      if (out_we) out_reg <= rd_val;
      if (wb_en && rd != '0) regs[rd] <= wb_val;
    end
  end

  always_ff @(posedge CLK) begin
    if (exec_en && dmem_we) dmem[mem_addr] <= rd_val;
  end

  assign imem_we = !RESET && wait_transport && rx_valid && byte_toggle;

  always_ff @(posedge CLK) begin
    if (RESET || !wait_transport) begin
      load_ptr    <= '0;
      byte_toggle <= 1'b0;
      lo_byte     <= '0;
    end else if (rx_valid) begin
      if (!byte_toggle) begin
        lo_byte     <= rx_data;
        byte_toggle <= 1'b1;
      end else begin
        byte_toggle <= 1'b0;
        load_ptr    <= load_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (imem_we) imem[load_ptr] <= {rx_data, lo_byte};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scan_cnt <= '0;
      digit    <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      digit    <= (digit == 3'd5) ? 3'd0 : digit + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    nibble = '0;
    case (digit)
      3'd0: nibble = out_reg[3:0];
      3'd1: nibble = out_reg[7:4];
      3'd2: nibble = out_reg[11:8];
      3'd3: nibble = out_reg[15:12];
      3'd4: nibble = pc[3:0];
      3'd5: nibble = pc[7:4];
      default: nibble = '0;
    endcase
  end

  assign seg  = hex_to_seg(nibble);
  assign sel  = ~(6'b000001 << digit);
  assign led1 = out_reg[0];
  assign led2 = out_reg[1];
  assign led3 = out_reg[2];
  assign led4 = out_reg[3];

endmodule

// File: tb/tb_single_cpu.sv
// Randomised self-checking bench for single_cpu against an instruction-level reference model.
module tb_single_cpu;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic       CLK = 1'b0;
  logic       RESET, wait_transport, uart_rx_pin;
  logic       led1, led2, led3, led4;
  logic [6:0] seg;
  logic [5:0] sel;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [15:0] m_imem [0:255];
  logic [15:0] m_dmem [0:255];
  logic [15:0] m_regs [0:7];
  logic [15:0] m_out;
  logic [7:0]  m_pc;
  bit          m_halted;
  logic [15:0] prog [$];

  single_cpu #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SCAN_DIV(4)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .wait_transport (wait_transport),
    .uart_rx_pin    (uart_rx_pin),
    .led1           (led1),
    .led2           (led2),
    .led3           (led3),
    .led4           (led4),
    .seg            (seg),
    .sel            (sel)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {4'(op), 3'(rd), 3'(rs1), 3'(rs2), 3'b000};
  endfunction

  function automatic logic [15:0] enc_i6(input int op, input int rd, input int rs1, input int imm);
    return {4'(op), 3'(rd), 3'(rs1), 6'(imm)};
  endfunction

  function automatic logic [15:0] enc_i9(input int op, input int rd, input int imm);
    return {4'(op), 3'(rd), 9'(imm)};
  endfunction

  function automatic int to_signed16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  function automatic logic [6:0] font(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic set_reg(input int r, input int val);
    if (r != 0) m_regs[r] = 16'(val);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_out = '0;
    m_pc = '0;
    m_halted = 1'b0;
  endtask

  // One clock edge of architectural execution.
  task automatic model_step();
    logic [15:0] ins;
    int op, rd, rs1, rs2, v, a, b, i6, i9, nxt;
    if (m_halted) return;
    ins = m_imem[m_pc];
    op  = int'(ins[15:12]);
    rd  = int'(ins[11:9]);
    rs1 = int'(ins[8:6]);
    rs2 = int'(ins[5:3]);
    v   = (rd  == 0) ? 0 : int'(m_regs[rd]);
    a   = (rs1 == 0) ? 0 : int'(m_regs[rs1]);
    b   = (rs2 == 0) ? 0 : int'(m_regs[rs2]);
    i6  = int'(ins[5:0]); if (i6 >= 32)  i6 -= 64;
    i9  = int'(ins[8:0]); if (i9 >= 256) i9 -= 512;
    nxt = int'(m_pc) + 1;
    case (op)
      1:  set_reg(rd, a + b);
      2:  set_reg(rd, a - b);
      3:  set_reg(rd, a & b);
      4:  set_reg(rd, a | b);
      5:  set_reg(rd, a ^ b);
      6:  set_reg(rd, (to_signed16(a) < to_signed16(b)) ? 1 : 0);
      7:  set_reg(rd, a + i6);
      8:  set_reg(rd, i9);
      9:  set_reg(rd, int'(m_dmem[(a + i6) & 255]));
      10: m_dmem[(a + i6) & 255] = 16'(v);
      11: if (v == a) nxt = int'(m_pc) + 1 + i6;
      12: nxt = int'(ins[7:0]);
      13: m_out = 16'(v);
      14: begin m_halted = 1'b1; nxt = int'(m_pc); end
      default: ;
    endcase
    m_pc = 8'(nxt & 255);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    uart_rx_pin = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      uart_rx_pin = b[i];
      repeat (CPB) @(negedge CLK);
    end
    uart_rx_pin = good_stop;
    repeat (CPB) @(negedge CLK);
    uart_rx_pin = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
  endtask

  task automatic load_program();
    @(negedge CLK);
    wait_transport = 1'b1;
    @(negedge CLK);
    m_pc = '0;
    m_halted = 1'b0;
    foreach (prog[i]) begin
      send_byte(prog[i][7:0], 1'b1);
      send_byte(prog[i][15:8], 1'b1);
      m_imem[i] = prog[i];
    end
  endtask

  task automatic run_cycles(input int n);
    wait_transport = 1'b0;
    repeat (n) begin
      @(negedge CLK);
      model_step();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    wait_transport = 1'b1;
    uart_rx_pin = 1'b1;
    repeat (2) @(negedge CLK);
    model_reset();
    checks_total++;
    if ({led4, led3, led2, led1} !== 4'b0000) $display("[TB] FAIL reset_leds: got %b expected 0000", {led4, led3, led2, led1});
    else checks_passed++;
    checks_total++;
    if (sel !== 6'b111110) $display("[TB] FAIL reset_sel: got %b expected 111110", sel);
    else checks_passed++;
    checks_total++;
    if (seg !== 7'b1000000) $display("[TB] FAIL reset_seg: got %b expected 1000000", seg);
    else checks_passed++;
    checks_total++;
    if (dut.pc !== 8'd0) $display("[TB] FAIL reset_pc: got %0d expected 0", dut.pc);
    else checks_passed++;
    RESET = 1'b0;
  endtask

  task automatic test_nop_run();
    prog = {};
    for (int i = 0; i < 10; i++) prog.push_back((i % 3 == 2) ? 16'hF000 : 16'h0000);
    prog.push_back(16'hE000);
    load_program();
    wait_transport = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      model_step();
      checks_total++;
      if (dut.pc !== 8'(i)) $display("[TB] FAIL nop_pc: got %0d expected %0d", dut.pc, i);
      else checks_passed++;
    end
  endtask

  task automatic test_load_run();
    prog = {};
    prog.push_back(enc_i9(8, 1, 5));
    prog.push_back(enc_i9(8, 2, 3));
    prog.push_back(enc_r(1, 3, 1, 2));
    prog.push_back(enc_r(13, 3, 0, 0));
    prog.push_back(16'hE000);
    load_program();
    run_cycles(5);
    checks_total++;
    if (dut.out_reg !== 16'd8) $display("[TB] FAIL load_run_out: got %h expected 0008", dut.out_reg);
    else checks_passed++;
    checks_total++;
    if ({led4, led3, led2, led1} !== 4'b1000) $display("[TB] FAIL load_run_leds: got %b expected 1000", {led4, led3, led2, led1});
    else checks_passed++;
    checks_total++;
    if (dut.pc !== 8'd4) $display("[TB] FAIL load_run_pc: got %0d expected 4", dut.pc);
    else checks_passed++;
    run_cycles(5);
    checks_total++;
    if (dut.pc !== 8'd4) $display("[TB] FAIL halt_hold_pc: got %0d expected 4", dut.pc);
    else checks_passed++;
  endtask

  task automatic test_branch_mem();
    prog = {};
    prog.push_back(enc_i9(8, 1, 7));
    prog.push_back(enc_i6(10, 1, 0, 2));
    prog.push_back(enc_i6(9, 2, 0, 2));
    prog.push_back(enc_i6(11, 1, 2, 1));
    prog.push_back(enc_r(13, 0, 0, 0));
    prog.push_back(enc_r(13, 2, 0, 0));
    prog.push_back(16'hE000);
    load_program();
    wait_transport = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      model_step();
      checks_total++;
      if (dut.out_reg !== m_out || dut.pc !== m_pc)
        $display("[TB] FAIL branch_step%0d: got out=%h pc=%0d expected out=%h pc=%0d", i, dut.out_reg, dut.pc, m_out, m_pc);
      else checks_passed++;
    end
    checks_total++;
    if (dut.out_reg !== 16'd7) $display("[TB] FAIL branch_out: got %h expected 0007", dut.out_reg);
    else checks_passed++;
    checks_total++;
    if (dut.dmem[2] !== 16'd7) $display("[TB] FAIL dmem2: got %h expected 0007", dut.dmem[2]);
    else checks_passed++;
  endtask

  task automatic test_bad_stop();
    logic [15:0] w0, w1, w2;
    w0 = enc_i9(8, 1, 9);
    w1 = enc_r(13, 1, 0, 0);
    w2 = 16'hE000;
    @(negedge CLK);
    wait_transport = 1'b1;
    @(negedge CLK);
    m_pc = '0;
    m_halted = 1'b0;
    send_byte(w0[7:0], 1'b1);
    send_byte(w0[15:8], 1'b1);
    send_byte(8'hD2, 1'b0);
    send_byte(w1[7:0], 1'b1);
    send_byte(w1[15:8], 1'b1);
    send_byte(w2[7:0], 1'b1);
    send_byte(w2[15:8], 1'b1);
    m_imem[0] = w0;
    m_imem[1] = w1;
    m_imem[2] = w2;
    checks_total++;
    if (dut.load_ptr !== 8'd3) $display("[TB] FAIL bad_stop_ptr: got %0d expected 3", dut.load_ptr);
    else checks_passed++;
    run_cycles(5);
    checks_total++;
    if (dut.out_reg !== 16'd9) $display("[TB] FAIL bad_stop_out: got %h expected 0009", dut.out_reg);
    else checks_passed++;
    checks_total++;
    if (dut.pc !== 8'd2) $display("[TB] FAIL bad_stop_pc: got %0d expected 2", dut.pc);
    else checks_passed++;
  endtask

  task automatic test_stall();
    logic [15:0] held;
    prog = {};
    prog.push_back(enc_i9(8, 1, 0));
    prog.push_back(enc_i6(7, 1, 1, 1));
    prog.push_back(enc_r(13, 1, 0, 0));
    prog.push_back(enc_i9(12, 0, 1));
    load_program();
    run_cycles(20);
    checks_total++;
    if (dut.out_reg !== m_out) $display("[TB] FAIL stall_prerun_out: got %h expected %h", dut.out_reg, m_out);
    else checks_passed++;
    held = m_out;
    wait_transport = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      m_pc = '0;
      m_halted = 1'b0;
      checks_total++;
      if (dut.pc !== 8'd0 || dut.out_reg !== held)
        $display("[TB] FAIL stall_hold: got pc=%0d out=%h expected pc=0 out=%h", dut.pc, dut.out_reg, held);
      else checks_passed++;
    end
    wait_transport = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      model_step();
      checks_total++;
      if (dut.out_reg !== m_out || dut.pc !== m_pc)
        $display("[TB] FAIL restart_step%0d: got out=%h pc=%0d expected out=%h pc=%0d", i, dut.out_reg, dut.pc, m_out, m_pc);
      else checks_passed++;
    end
    wait_transport = 1'b1;
    m_pc = '0;
    m_halted = 1'b0;
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 3; iter++) begin
      int len, kind, known[$];
      len = $urandom_range(8, 14);
      known = {};
      for (int a = 0; a < 16; a++) if (!$isunknown(m_dmem[a])) known.push_back(a);
      prog = {};
      for (int i = 0; i < len - 1; i++) begin
        int rd, rs1, rs2, maxk;
        rd  = $urandom_range(0, 7);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        kind = $urandom_range(0, 12);
        case (kind)
          0, 1, 2, 3, 4, 5: prog.push_back(enc_r(kind + 1, rd, rs1, rs2));
          6:  prog.push_back(enc_i6(7, rd, rs1, $urandom_range(0, 63)));
          7:  prog.push_back(enc_i9(8, rd, $urandom_range(0, 511)));
          8:  prog.push_back(enc_i6(10, rd, 0, $urandom_range(8, 15)));
          9:  if (known.size() > 0) prog.push_back(enc_i6(9, rd, 0, known[$urandom_range(0, known.size() - 1)]));
              else prog.push_back(16'h0000);
          10: begin
            maxk = len - 2 - i;
            if (maxk > 2) maxk = 2;
            prog.push_back(enc_i6(11, rd, ($urandom_range(0, 1) == 1) ? rd : rs1, $urandom_range(0, maxk)));
          end
          11: prog.push_back(enc_r(13, rd, 0, 0));
          default: prog.push_back(16'h0000);
        endcase
      end
      prog.push_back(16'hE000);
      load_program();
      run_cycles(len + 2);
      checks_total++;
      if (dut.pc !== m_pc || dut.out_reg !== m_out)
        $display("[TB] FAIL random%0d_pc_out: got pc=%0d out=%h expected pc=%0d out=%h", iter, dut.pc, dut.out_reg, m_pc, m_out);
      else checks_passed++;
      for (int r = 1; r < 8; r++) begin
        checks_total++;
        if (dut.regs[r] !== m_regs[r]) $display("[TB] FAIL random%0d_r%0d: got %h expected %h", iter, r, dut.regs[r], m_regs[r]);
        else checks_passed++;
      end
      for (int a = 8; a < 16; a++) begin
        if (!$isunknown(m_dmem[a])) begin
          checks_total++;
          if (dut.dmem[a] !== m_dmem[a]) $display("[TB] FAIL random%0d_dmem%0d: got %h expected %h", iter, a, dut.dmem[a], m_dmem[a]);
          else checks_passed++;
        end
      end
    end
  endtask

  task automatic test_display();
    logic [5:0] prev;
    int idx, nib, waited;
    bit found;
    prog = {};
    prog.push_back(enc_i9(8, 1, 9'h091));
    for (int i = 0; i < 5; i++) prog.push_back(enc_r(1, 1, 1, 1));
    prog.push_back(enc_i6(7, 1, 1, 20));
    prog.push_back(enc_r(13, 1, 0, 0));
    prog.push_back(16'hE000);
    load_program();
    run_cycles(12);
    checks_total++;
    if (dut.out_reg !== 16'h1234 || m_out !== 16'h1234) $display("[TB] FAIL display_out: got %h expected 1234", dut.out_reg);
    else checks_passed++;
    prev = sel;
    waited = 0;
    while (sel === prev && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < 6; i++) if (sel === ~(6'b000001 << i)) begin idx = i; found = 1'b1; end
    checks_total++;
    if (!found || waited >= 10) $display("[TB] FAIL scan_start: got sel=%b expected a one-hot-low change", sel);
    else checks_passed++;
    for (int w = 0; w < 12; w++) begin
      for (int c = 0; c < 4; c++) begin
        if (w != 0 || c != 0) @(negedge CLK);
        checks_total++;
        if (sel !== ~(6'b000001 << idx)) $display("[TB] FAIL scan_sel: got %b expected %b", sel, ~(6'b000001 << idx));
        else checks_passed++;
        if (c == 0) begin
          nib = (idx < 4) ? ((int'(m_out) >> (4 * idx)) & 15) : ((int'(m_pc) >> (4 * (idx - 4))) & 15);
          checks_total++;
          if (seg !== font(nib)) $display("[TB] FAIL scan_seg%0d: got %b expected %b", idx, seg, font(nib));
          else checks_passed++;
        end
      end
      idx = (idx + 1) % 6;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_imem[i] = 'x;
      m_dmem[i] = 'x;
    end
    test_reset();
    test_nop_run();
    test_load_run();
    test_branch_mem();
    test_bad_stop();
    test_stall();
    test_random();
    test_display();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
